// File: rtl/ascon_ti_pkg.sv
// Shared constants and types for the three-share Ascon state unmasking block.
package ascon_ti_pkg;

    localparam int NUM_SHARES = 3;
    localparam int NUM_LANES  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FOLD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_SEND  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    typedef logic [2:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(NUM_LANES - 1);

endpackage

// File: rtl/ascon_ti_unmask.sv
// Recombines a 3-share masked Ascon state one share per cycle, then streams
// the five unmasked 64-bit lanes out over a valid/ready port, zeroizing after.
module ascon_ti_unmask
    import ascon_ti_pkg::*;
#(
    parameter int LANE_W = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [NUM_LANES*LANE_W-1:0] s_share0,
    input  logic [NUM_LANES*LANE_W-1:0] s_share1,
    input  logic [NUM_LANES*LANE_W-1:0] s_share2,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [LANE_W-1:0]           m_data,
    output logic                        m_last,
    output logic [2:0]                  dbg_state
);

    localparam int STATE_W = NUM_LANES * LANE_W;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // m_valid, m_data and m_last stay stable from assertion until that edge.

    state_t             r_state;
    logic [STATE_W-1:0] r_sh0;
    logic [STATE_W-1:0] r_sh1;
    logic [STATE_W-1:0] r_sh2;
    logic [STATE_W-1:0] r_acc;
    lane_idx_t          r_idx;
    logic [LANE_W-1:0]  w_lane;
    logic               w_send;

    assign w_send    = (r_state == ST_SEND);
    assign s_ready   = (r_state == ST_IDLE) && !clr;
    assign m_valid   = w_send;
    assign m_data    = w_send ? w_lane : '0;
    assign m_last    = w_send && (r_idx == LAST_LANE);
    assign dbg_state = r_state;

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_idx == lane_idx_t'(i)) begin
                w_lane = r_acc[i*LANE_W +: LANE_W];
            end
        end
    end

    // Shares are only ever folded from registers, one share per step, so no
    // path combines more than one input share combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_sh0   <= s_share0;
                        r_sh1   <= s_share1;
                        r_sh2   <= s_share2;
                        r_state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    r_acc   <= r_sh0 ^ r_sh1;
                    r_sh0   <= '0;
                    r_sh1   <= '0;
                    r_state <= ST_MERGE;
                end
                ST_MERGE: begin
                    r_acc   <= r_acc ^ r_sh2;
                    r_sh2   <= '0;
                    r_idx   <= '0;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_ready) begin
                        if (r_idx == LAST_LANE) begin
                            r_state <= ST_CLEAR;
                        end else begin
                            r_idx <= r_idx + lane_idx_t'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_ti_unmask.sv
// Randomized scoreboard bench for ascon_ti_unmask: each accepted state pushes
// its five plaintext lanes; a negedge monitor pops and compares on handshakes.
module tb_ascon_ti_unmask;

    localparam int W  = 64;
    localparam int SW = 5 * W;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_share0;
    logic [SW-1:0] s_share1;
    logic [SW-1:0] s_share2;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic [2:0]    dbg_state;

    ascon_ti_unmask #(.LANE_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_share0  (s_share0),
        .s_share1  (s_share1),
        .s_share2  (s_share2),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_last_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    initial begin
        logic [W-1:0] ed;
        logic         el;
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_lane", $sformatf("m_valid=1 with nothing expected, m_data=%h", m_data));
                end else if (m_ready) begin
                    ed = exp_q.pop_front();
                    el = exp_last_q.pop_front();
                    check("lane_data", m_data, ed);
                    check_bit("lane_last", m_last, el);
                end
            end
        end
    end

    // ---------------- reference model / drivers ----------------
    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // The plaintext lanes are the expected output; shares are a fresh random split.
    task automatic load_shares(input logic [SW-1:0] x);
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        s0 = rand_state();
        s1 = rand_state();
        s_share0 = s0;
        s_share1 = s1;
        s_share2 = x ^ s0 ^ s1;
    endtask

    task automatic push_expected(input logic [SW-1:0] x);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(x[i*W +: W]);
            exp_last_q.push_back(i == 4);
        end
    endtask

    // Entered and left at #1 after a rising edge; returns the accept-edge cycle.
    task automatic send_state(input logic [SW-1:0] x, output int acc_cyc);
        int waited;
        load_shares(x);
        s_valid = 1'b1;
        waited  = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            fail_now("accept_timeout", "s_ready never asserted");
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            s_valid = 1'b0;
            push_expected(x);
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !s_ready) && b < 300) begin
            @(posedge clk);
            b++;
        end
        check("drain_left", W'(exp_q.size()), '0);
        #1;
    endtask

    task automatic flush_expected();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    task automatic check_quiet(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check(name, W'(seen), '0);
    endtask

    // ---------------- test sequence ----------------
    logic [SW-1:0] x_ref;
    int            acc_c;
    int            times[4];
    int            accepts;
    int            budget;
    logic          done;

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        s_valid  = 1'b0;
        m_ready  = 1'b1;
        s_share0 = '0;
        s_share1 = '0;
        s_share2 = '0;
        done     = 1'b0;
        x_ref    = {64'hA5A5A5A5A5A5A5A5, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                    64'hFEDCBA9876543210, 64'h0123456789ABCDEF};

        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_s_ready", s_ready, 1'b1);
        check_bit("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check_bit("rst_m_last", m_last, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero state: five zero lanes, last only on the fifth.
        send_state('0, acc_c);
        wait_drain();

        // Known sharing, with accept-to-valid latency of two edges.
        send_state(x_ref, acc_c);
        @(negedge clk);
        check_bit("lat_edge1", m_valid, 1'b0);
        @(negedge clk);
        check_bit("lat_edge2", m_valid, 1'b0);
        @(negedge clk);
        check_bit("lat_valid", m_valid, 1'b1);
        @(posedge clk);
        #1;
        wait_drain();

        // Back-pressure at lane 2 (x2 is zero): outputs hold for three cycles.
        send_state(x_ref, acc_c);
        budget = 0;
        while (exp_q.size() != 3 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_bit("stall_valid", m_valid, 1'b1);
            check("stall_data", m_data, '0);
            check_bit("stall_last", m_last, 1'b0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();

        // Flush while lane 1 is presented, then a fresh state must unmask.
        send_state(x_ref, acc_c);
        budget = 0;
        while (exp_q.size() != 4 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        clr     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        check("clr_lane1_data", m_data, x_ref[W +: W]);
        check_bit("clr_s_ready_low", s_ready, 1'b0);
        @(posedge clk);
        #1;
        clr     = 1'b0;
        m_ready = 1'b1;
        flush_expected();
        @(negedge clk);
        check_bit("clr_m_valid", m_valid, 1'b0);
        check_bit("clr_s_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        send_state(rand_state(), acc_c);
        wait_drain();

        // Reset asserted during MERGE.
        send_state(rand_state(), acc_c);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("rstm_m_valid", m_valid, 1'b0);
        check("rstm_m_data", m_data, '0);
        check_bit("rstm_m_last", m_last, 1'b0);
        check_bit("rstm_s_ready", s_ready, 1'b1);
        flush_expected();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_quiet("rstm_quiet", 12);
        @(posedge clk);
        #1;

        // Reset asserted during a stalled SEND.
        m_ready = 1'b0;
        send_state(rand_state(), acc_c);
        repeat (2) @(posedge clk);
        #1;
        check_bit("rsts_in_send", m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("rsts_m_valid", m_valid, 1'b0);
        check("rsts_m_data", m_data, '0);
        flush_expected();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        check_quiet("rsts_quiet", 12);
        @(posedge clk);
        #1;

        // s_valid held high: accepts every nine cycles.
        x_ref = rand_state();
        load_shares(x_ref);
        s_valid = 1'b1;
        accepts = 0;
        budget  = 0;
        while (accepts < 4 && budget < 100) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                times[accepts] = cyc;
                accepts++;
                push_expected(x_ref);
                x_ref = rand_state();
                load_shares(x_ref);
            end
            budget++;
        end
        s_valid = 1'b0;
        check("b2b_accepts", W'(accepts), W'(4));
        for (int i = 1; i < 4; i++) begin
            check("b2b_gap", W'(times[i] - times[i-1]), W'(9));
        end
        wait_drain();

        // Random states under random back-pressure.
        fork
            begin
                for (int i = 0; i < 6; i++) send_state(rand_state(), acc_c);
                wait_drain();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        check_quiet("final_quiet", 5);
        check("final_queue", W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_ti_unmask.md
ASCON_TI_UNMASK -- requirements
Module: ascon_ti_unmask

Interface
REQ-001 SHALL have parameter LANE_W, default 64, giving the lane width in bits.
REQ-002 SHALL have clk, input, 1: the single clock; every register is rising-edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have clr, input, 1: synchronous flush and zeroize.
REQ-005 SHALL have s_valid, input, 1: a 3-share masked state is offered.
REQ-006 SHALL have s_ready, output, 1: the block accepts a state.
REQ-007 SHALL have s_share0, s_share1, s_share2, each input, 5*LANE_W: one share each; lane i (x0..x4) occupies bits [i*LANE_W +: LANE_W].
REQ-008 SHALL have m_valid, output, 1: an unmasked lane is presented.
REQ-009 SHALL have m_ready, input, 1: the sink accepts the lane.
REQ-010 SHALL have m_data, output, LANE_W: the unmasked lane.
REQ-011 SHALL have m_last, output, 1: high with lane x4.

Function
REQ-012 SHALL implement states IDLE, FOLD, MERGE, SEND and CLEAR.
REQ-013 SHALL drive s_ready = (state==IDLE) && !clr.
REQ-014 In IDLE, on s_valid && s_ready, SHALL register all three shares into sh0, sh1 and sh2, then go to FOLD.
REQ-015 In FOLD, SHALL set acc <= sh0 ^ sh1, zero sh0 and sh1, then go to MERGE.
REQ-016 In MERGE, SHALL set acc <= acc ^ sh2, zero sh2, set lane index idx <= 0, then go to SEND.
REQ-017 SHALL never combine shares combinationally from input ports; shares are recombined only in registered steps, one share at a time.
REQ-018 In SEND, SHALL drive m_valid=1, m_data=acc lane idx and m_last=(idx==4).
REQ-019 In SEND, on m_valid && m_ready with idx<4, SHALL increment idx.
REQ-020 In SEND, on m_valid && m_ready with idx==4, SHALL go to CLEAR.
REQ-021 While in SEND with m_ready=0, SHALL hold m_data, m_last and idx stable; m_valid SHALL NOT drop before the handshake.
REQ-022 In CLEAR, SHALL zero acc and idx, then go to IDLE.
REQ-023 Outside SEND, SHALL drive m_valid=0, m_data=0 and m_last=0.
REQ-024 Latency: for an accept at edge N, SHALL assert m_valid after edge N+2.
REQ-025 Minimum period between accepts SHALL be 9 cycles, with m_ready held high.
REQ-026 When clr=1 in any state, SHALL at the next edge zero sh0, sh1, sh2, acc and idx, and go to IDLE.
REQ-027 When clr and s_valid are both high, clr SHALL win and no capture SHALL occur.
REQ-028 When clr and the final SEND handshake occur together, the lane counts as transferred and SHALL go to IDLE via flush.
REQ-029 idx SHALL be 3 bits and SHALL never exceed 4; no wrap-around.

Reset
REQ-030 On rst_n=0, SHALL asynchronously set state=IDLE and zero sh0, sh1, sh2, acc and idx.
REQ-031 During reset, SHALL drive s_ready=1, m_valid=0, m_data=0 and m_last=0.
REQ-032 Reset asserted mid-SEND SHALL abort the transfer; after release no residual lane appears and no data is emitted.

Structure
REQ-033 Package ascon_ti_pkg SHALL hold: NUM_SHARES=3, NUM_LANES=5, the state enum type, and the lane-index type.
REQ-034 SHALL be one flat module with the lane mux inline; no sub-module.

Verification
REQ-035 With all shares 0, SHALL output 5 lanes of 0 and m_last only on the 5th lane.
REQ-036 Sharing check: x = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5}, s0 random, s1 random, s2 = x^s0^s1 -> SHALL output exactly x0..x4 in order, first m_valid 2 cycles after accept.
REQ-037 m_ready low for 3 cycles at lane 2 -> m_data SHALL stay 0 while m_valid stays 1; output completes afterwards.
REQ-038 clr pulsed during lane 1 -> SHALL set m_valid=0 next cycle and s_ready=1; a following state SHALL unmask correctly.
REQ-039 rst_n low in MERGE -> all outputs SHALL be 0 immediately; no output after release until a new accept.
REQ-040 s_valid held high continuously -> accepts SHALL be spaced exactly 9 cycles apart with m_ready=1.
